// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding and the baud divider calculation.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2
  } rx_state_t;

  // Clock cycles per oversample tick, rounded to the nearest integer.
  function automatic int div_calc(input int clk_freq_hz, input int baud_rate,
                                  input int oversample);
    int tick_rate;
    tick_rate = baud_rate * oversample;
    return (clk_freq_hz + tick_rate / 2) / tick_rate;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous input plus a falling-edge detector.
module sync_edge #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic fall
);

  logic meta;
  logic prev;

  // Metastability stages and the previous-value flop, all preset to the idle level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
      prev <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
      prev <= q;
    end
  end

  assign fall = prev & ~q;

endmodule

// File: rtl/rx_tick_gen.sv
// UART receive timing: start-bit detection and validation, and the oversample,
// first-data-bit and per-bit sampling strobes consumed by the receiver.
module rx_tick_gen
  import uart_pkg::*;
#(
  parameter int DATA_SIZE   = 7,
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int OVERSAMPLE  = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic receive_line,
  output logic sample_tick,
  output logic bit_tick_one_and_half,
  output logic bit_tick,
  output logic rx_sync,
  output logic busy,
  output logic glitch
);

  localparam int DIV     = div_calc(CLK_FREQ_HZ, BAUD_RATE, OVERSAMPLE);
  localparam int PRESC_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int SCNT_W  = $clog2(OVERSAMPLE * (DATA_SIZE + 2));
  localparam int HALF_I  = OVERSAMPLE / 2;

  localparam logic [PRESC_W-1:0] PRESC_MAX  = PRESC_W'(DIV - 1);
  localparam logic [SCNT_W-1:0]  MID_TICK   = SCNT_W'(HALF_I);
  localparam logic [SCNT_W-1:0]  FIRST_TICK = SCNT_W'(3 * HALF_I);
  localparam logic [SCNT_W-1:0]  STOP_TICK  = SCNT_W'(3 * HALF_I + DATA_SIZE * OVERSAMPLE);

  if (DIV < 2) begin : g_div_check
    $error("rx_tick_gen: clock too slow for BAUD_RATE*OVERSAMPLE (DIV < 2)");
  end
  if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : g_os_check
    $error("rx_tick_gen: OVERSAMPLE must be even and at least 4");
  end

  rx_state_t          state, state_nxt;
  logic [PRESC_W-1:0] presc, presc_nxt;
  logic [SCNT_W-1:0]  scnt, scnt_nxt;
  logic               fall;
  logic               start_entry;
  logic               tick_nxt;
  logic               boh_nxt;
  logic               bit_nxt;
  logic               glitch_nxt;

  // Sampling points of data bits 1..DATA_SIZE-1 and the stop bit.
  function automatic logic is_bit_point(input logic [SCNT_W-1:0] n);
    logic hit;
    hit = 1'b0;
    for (int k = 1; k <= DATA_SIZE; k++) begin
      if (n == SCNT_W'(3 * HALF_I + k * OVERSAMPLE)) hit = 1'b1;
    end
    return hit;
  endfunction

  sync_edge #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (receive_line),
    .q    (rx_sync),
    .fall (fall)
  );

  // Frame FSM: transitions happen at the end of the tick cycle that decides them.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (fall) state_nxt = ST_START;
      ST_START: begin
        if (sample_tick && (scnt == MID_TICK) && glitch) state_nxt = ST_IDLE;
        else if (sample_tick && (scnt == FIRST_TICK))    state_nxt = ST_DATA;
      end
      ST_DATA:  if (sample_tick && (scnt == STOP_TICK)) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Next-cycle view of the counters; strobes are decided one cycle early so they
  // can leave the block straight from flops, aligned with their sample_tick.
  always_comb begin
    start_entry = (state == ST_IDLE) && fall;
    presc_nxt   = '0;
    if (!start_entry && (presc != PRESC_MAX)) presc_nxt = presc + PRESC_W'(1);
    tick_nxt = (presc_nxt == PRESC_MAX);
    scnt_nxt = scnt;
    if (start_entry)                                scnt_nxt = '0;
    else if ((state_nxt != ST_IDLE) && tick_nxt)    scnt_nxt = scnt + SCNT_W'(1);
    boh_nxt    = (state_nxt == ST_START) && tick_nxt && (scnt_nxt == FIRST_TICK);
    glitch_nxt = (state_nxt == ST_START) && tick_nxt && (scnt_nxt == MID_TICK) && rx_sync;
    bit_nxt    = (state_nxt == ST_DATA) && tick_nxt && is_bit_point(scnt_nxt);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                 <= ST_IDLE;
      presc                 <= '0;
      scnt                  <= '0;
      sample_tick           <= 1'b0;
      bit_tick_one_and_half <= 1'b0;
      bit_tick              <= 1'b0;
      busy                  <= 1'b0;
      glitch                <= 1'b0;
    end else begin
      state                 <= state_nxt;
      presc                 <= presc_nxt;
      scnt                  <= scnt_nxt;
      sample_tick           <= tick_nxt;
      bit_tick_one_and_half <= boh_nxt;
      bit_tick              <= bit_nxt;
      busy                  <= (state_nxt != ST_IDLE);
      glitch                <= glitch_nxt;
    end
  end

endmodule
